// File: rtl/mult_complete_queue_pkg.sv
// rtl/mult_complete_queue_pkg.sv - shared packet type and sizing for the mult completion queue
package mult_complete_queue_pkg;

  localparam int MUL_STAGE    = 4;
  localparam int MUL_CQ_DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic        halt;
    logic [5:0]  dest_pr;
    logic [31:0] dest_value;
    logic [4:0]  rob_entry;
  } fu_complete_packet;

endpackage

// File: rtl/mult_complete_queue.sv
// rtl/mult_complete_queue.sv - credit-stalled result skid FIFO between fu_mult and CDB arbitration
module mult_complete_queue
  import mult_complete_queue_pkg::*;
#(
  parameter int DEPTH     = MUL_CQ_DEPTH,
  parameter int IN_FLIGHT = MUL_STAGE
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     want_to_complete,
  input  fu_complete_packet        fu_packet_in,
  input  logic                     cdb_grant,
  output logic                     complete_stall,
  output logic                     out_valid,
  output fu_complete_packet        packet_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH <= IN_FLIGHT || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("mult_complete_queue: DEPTH must be a power of 2 greater than IN_FLIGHT");
  end

  fu_complete_packet entry [DEPTH];
  logic [PW-1:0]     head, tail;
  logic              push, pop, full;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = want_to_complete & fu_packet_in.valid & ~flush;
  assign pop       = out_valid & cdb_grant & ~flush;

  // Credit stall: keep a free slot for every op already inside the multiplier.
  assign complete_stall = (count >= CW'(DEPTH - IN_FLIGHT));

  always_comb begin
    packet_out = '0;
    if (out_valid) begin
      packet_out       = entry[head];
      packet_out.valid = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry[i].valid <= 1'b0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // A full queue still accepts a push when the head leaves in the same cycle.
      if (push && (!full || pop)) begin
        entry[tail] <= fu_packet_in;
        tail        <= tail + PW'(1);
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if ((push && (!full || pop)) && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !(push && (!full || pop))) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mult_complete_queue.sv
// tb/tb_mult_complete_queue.sv - directed and stall-honouring random checks for mult_complete_queue
module tb_mult_complete_queue;
  import mult_complete_queue_pkg::*;

  logic              clock = 1'b0;
  logic              reset, flush, want_to_complete, cdb_grant;
  fu_complete_packet fu_packet_in, packet_out;
  logic              complete_stall, out_valid, overflow;
  logic [3:0]        count;

  int n_pass = 0;
  int n_checks = 0;

  mult_complete_queue #(.DEPTH(8), .IN_FLIGHT(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .want_to_complete(want_to_complete), .fu_packet_in(fu_packet_in),
    .cdb_grant(cdb_grant), .complete_stall(complete_stall),
    .out_valid(out_valid), .packet_out(packet_out), .count(count),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic fu_complete_packet mk(input logic [4:0] rob, input logic [31:0] val);
    fu_complete_packet p;
    p.valid      = 1'b1;
    p.halt       = rob[0];
    p.dest_pr    = {1'b0, rob};
    p.dest_value = val;
    p.rob_entry  = rob;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [31:0] val);
    want_to_complete = 1'b1;
    fu_packet_in     = mk(5'(val), val);
    tick();
    want_to_complete = 1'b0;
    fu_packet_in     = '0;
  endtask

  fu_complete_packet pipe [4];
  logic [31:0]       exp_q [$];
  logic [31:0]       seq;
  logic              start;

  initial begin
    reset = 1'b0; flush = 1'b0; cdb_grant = 1'b0;
    want_to_complete = 1'b1; fu_packet_in = mk(5'd1, 32'hdead);
    tick(); tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_stall", 64'(complete_stall), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_packet", 64'(packet_out), 64'd0);
    want_to_complete = 1'b0; fu_packet_in = '0;
    reset = 1'b1;
    tick();

    // single push, then one grant
    want_to_complete = 1'b1; fu_packet_in = mk(5'd3, 32'h1234);
    check("no_bypass", 64'(out_valid), 64'd0);
    tick();
    want_to_complete = 1'b0; fu_packet_in = '0;
    check("t2_out_valid", 64'(out_valid), 64'd1);
    check("t2_dest_value", 64'(packet_out.dest_value), 64'h1234);
    check("t2_packet", 64'(packet_out), 64'(mk(5'd3, 32'h1234)));
    check("t2_count", 64'(count), 64'd1);
    cdb_grant = 1'b1; tick(); cdb_grant = 1'b0;
    check("t2_count_after_pop", 64'(count), 64'd0);
    check("t2_packet_empty", 64'(packet_out), 64'd0);

    // credit stall threshold at count == DEPTH - IN_FLIGHT
    for (int i = 0; i < 4; i++) begin
      push_one(32'h10 + 32'(i));
      check("t3_stall", 64'(complete_stall), (i == 3) ? 64'd1 : 64'd0);
    end
    check("t3_count", 64'(count), 64'd4);
    check("t3_head", 64'(packet_out.dest_value), 64'h10);
    cdb_grant = 1'b1; tick(); cdb_grant = 1'b0;
    check("t3_count_pop", 64'(count), 64'd3);
    check("t3_stall_pop", 64'(complete_stall), 64'd0);

    // fill to DEPTH, push+pop when full, then overflow
    for (int i = 0; i < 5; i++) push_one(32'h14 + 32'(i));
    check("t4_full", 64'(count), 64'd8);
    check("t4_stall_full", 64'(complete_stall), 64'd1);
    cdb_grant = 1'b1; want_to_complete = 1'b1; fu_packet_in = mk(5'h19, 32'h19);
    tick();
    cdb_grant = 1'b0; want_to_complete = 1'b0;
    check("t4_full_pushpop_count", 64'(count), 64'd8);
    check("t4_no_overflow", 64'(overflow), 64'd0);
    push_one(32'h1a);
    check("t4_overflow", 64'(overflow), 64'd1);
    check("t4_count_overflow", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check("t4_order", 64'(packet_out.dest_value), 64'h12 + 64'(i));
      cdb_grant = 1'b1; tick(); cdb_grant = 1'b0;
    end
    check("t4_drained", 64'(count), 64'd0);

    // flush wins over same-cycle push and pop
    for (int i = 0; i < 3; i++) push_one(32'h20 + 32'(i));
    check("t5_count", 64'(count), 64'd3);
    flush = 1'b1; cdb_grant = 1'b1; want_to_complete = 1'b1; fu_packet_in = mk(5'h3, 32'h23);
    tick();
    flush = 1'b0; cdb_grant = 1'b0; want_to_complete = 1'b0;
    check("t5_count_flush", 64'(count), 64'd0);
    check("t5_out_valid_flush", 64'(out_valid), 64'd0);
    check("t5_overflow_kept", 64'(overflow), 64'd1);
    push_one(32'h24);
    check("t5_after_flush_count", 64'(count), 64'd1);
    check("t5_after_flush_head", 64'(packet_out.dest_value), 64'h24);

    reset = 1'b0; tick(); reset = 1'b1;
    check("t6_overflow_cleared", 64'(overflow), 64'd0);

    // random traffic from a 4-stage multiplier that honours complete_stall
    for (int s = 0; s < 4; s++) pipe[s] = '0;
    seq = 32'h1000;
    for (int c = 0; c < 1000; c++) begin
      want_to_complete = pipe[3].valid;
      fu_packet_in     = pipe[3];
      cdb_grant        = ($urandom_range(0, 2) != 0);
      start            = !complete_stall && ($urandom_range(0, 3) != 0);
      if (out_valid && cdb_grant) begin
        if (exp_q.size() == 0) check("t6_unexpected_pop", 64'(packet_out.dest_value), 64'hffffffff);
        else check("t6_order", 64'(packet_out.dest_value), 64'(exp_q.pop_front()));
      end
      if (want_to_complete) exp_q.push_back(fu_packet_in.dest_value);
      tick();
      for (int s = 3; s > 0; s--) pipe[s] = pipe[s-1];
      if (start) begin
        pipe[0] = mk(5'(seq), seq);
        seq++;
      end else begin
        pipe[0] = '0;
      end
    end
    want_to_complete = 1'b0; fu_packet_in = '0;
    check("t6_overflow_never", 64'(overflow), 64'd0);
    check("t6_count_matches", 64'(count), 64'(exp_q.size()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
